// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
//   Shared types and defaults for the output-stationary systolic matmul core.
//   - TPU_* localparams : default array edge, data/acc widths, dim/index widths
//   - tpu_state_e       : controller FSM states
//   - ceil_div()        : tile-count helper (ceil(a/b))
// -----------------------------------------------------------------------------
package tpu_pkg;

  localparam int TPU_P      = 4;
  localparam int TPU_DATA_W = 8;
  localparam int TPU_ACC_W  = 32;
  localparam int TPU_DIM_W  = 8;
  localparam int TPU_IDX_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_WRITE
  } tpu_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/tpu_pe.sv
// -----------------------------------------------------------------------------
// tpu_pe
//   One multiply-accumulate cell of the systolic grid. Operands arrive from the
//   west (a) and north (b), are multiplied into the local accumulator and are
//   forwarded east/south one cycle later.
//   Optional build macro TPU_INPUT_OFFSET_EN: adds off_i to a (signed, DATA_W+1
//   bit adder) before the multiply, for zero-point corrected quantised inputs.
// Ports
//   clk, rst_n  clock, async active-low reset
//   clr_i       synchronous accumulator clear
//   a_i, b_i    signed operands (DATA_W)
//   off_i       signed a-offset (DATA_W+1), offset build only
//   a_o, b_o    registered pass-through operands
//   acc_o       accumulator (ACC_W, wraps)
// -----------------------------------------------------------------------------
module tpu_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic [DATA_W-1:0]        a_i,
  input  logic [DATA_W-1:0]        b_i,
`ifdef TPU_INPUT_OFFSET_EN
  input  logic signed [DATA_W:0]   off_i,
`endif
  output logic [DATA_W-1:0]        a_o,
  output logic [DATA_W-1:0]        b_o,
  output logic [ACC_W-1:0]         acc_o
);

`ifdef TPU_INPUT_OFFSET_EN
  localparam int PW = 2 * DATA_W + 1;
  logic signed [DATA_W:0] a_x;
  // offset add wraps in DATA_W+1 bits
  assign a_x = $signed({a_i[DATA_W-1], a_i}) + off_i;
  logic signed [PW-1:0] a_s, b_s, prod;
  assign a_s = $signed({{(PW-DATA_W-1){a_x[DATA_W]}}, a_x});
`else
  localparam int PW = 2 * DATA_W;
  logic signed [PW-1:0] a_s, b_s, prod;
  assign a_s = $signed({{(PW-DATA_W){a_i[DATA_W-1]}}, a_i});
`endif
  assign b_s  = $signed({{(PW-DATA_W){b_i[DATA_W-1]}}, b_i});
  assign prod = a_s * b_s;

  logic [DATA_W-1:0] a_q, b_q;
  logic [ACC_W-1:0]  acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      if (clr_i) acc_q <= '0;
      else       acc_q <= acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/tpu_systolic_core.sv
// -----------------------------------------------------------------------------
// tpu_systolic_core
//   Output-stationary PxP systolic engine computing C[MxN] = A[MxK] * B[KxN]
//   tile by tile (nt outer, mt inner). Each tile: LOAD (clear), FEED (K reads
//   plus one cycle for SRAM latency), DRAIN (2P-1 cycles of zeros), WRITE
//   (P rows of C). A/B buffers are 1-cycle synchronous-read SRAMs.
//   Optional build macro TPU_INPUT_OFFSET_EN: adds port A_offset, captured
//   with K/M/N and added to every A element inside the PEs.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid, K, M, N          command; accepted only while busy==0
//   A_offset                   signed A zero-point (offset build only)
//   busy                       command in progress
//   A_/B_ wr_en,index,data_in  read-only usage: wr_en/data_in tied 0
//   A_/B_ data_out             P lanes of DATA_W read data
//   C_wr_en, C_index, C_data_in  P lanes of ACC_W result row
//   C_data_out                 unused
// -----------------------------------------------------------------------------
module tpu_systolic_core import tpu_pkg::*; #(
  parameter int P      = TPU_P,
  parameter int DATA_W = TPU_DATA_W,
  parameter int ACC_W  = TPU_ACC_W,
  parameter int DIM_W  = TPU_DIM_W,
  parameter int IDX_W  = TPU_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DIM_W-1:0]      K,
  input  logic [DIM_W-1:0]      M,
  input  logic [DIM_W-1:0]      N,
`ifdef TPU_INPUT_OFFSET_EN
  input  logic signed [DATA_W:0] A_offset,
`endif
  output logic                  busy,
  output logic                  A_wr_en,
  output logic [IDX_W-1:0]      A_index,
  output logic [P*DATA_W-1:0]   A_data_in,
  input  logic [P*DATA_W-1:0]   A_data_out,
  output logic                  B_wr_en,
  output logic [IDX_W-1:0]      B_index,
  output logic [P*DATA_W-1:0]   B_data_in,
  input  logic [P*DATA_W-1:0]   B_data_out,
  output logic                  C_wr_en,
  output logic [IDX_W-1:0]      C_index,
  output logic [P*ACC_W-1:0]    C_data_in,
  input  logic [P*ACC_W-1:0]    C_data_out
);

  localparam int CNT_W = DIM_W + 1;

  tpu_state_e                state_q;
  logic                      busy_q, rd_vld_q, c_wr_q;
  logic [DIM_W-1:0]          k_q, m_q, n_q, mt_q, nt_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [IDX_W-1:0]          a_idx_q, b_idx_q, c_idx_q;
  logic [P-1:0][ACC_W-1:0]   c_data_q;
`ifdef TPU_INPUT_OFFSET_EN
  logic signed [DATA_W:0]    off_q;
`endif

  // ---------------- tile bookkeeping ----------------
  logic                    last_mt, last_nt, row_ok;
  logic [CNT_W-1:0]        nrow;
  logic [P-1:0][ACC_W-1:0] row_data;
  logic [IDX_W-1:0]        c_base;

  assign last_mt = (int'(mt_q) + 1) >= ceil_div(int'(m_q), P);
  assign last_nt = (int'(nt_q) + 1) >= ceil_div(int'(n_q), P);
  assign c_base  = IDX_W'(int'(nt_q) * int'(m_q) + int'(mt_q) * P);

  // row registered at the end of this cycle: 0 on DRAIN->WRITE, else r+1
  assign nrow   = (state_q == S_WRITE) ? cnt_q + 1'b1 : '0;
  assign row_ok = (int'(mt_q) * P + int'(nrow)) < int'(m_q);

  logic [ACC_W-1:0] acc [P][P];

  // row select; columns past N are forced to zero
  always_comb begin
    row_data = '0;
    for (int r = 0; r < P; r++)
      if (nrow == CNT_W'(r))
        for (int j = 0; j < P; j++)
          if (int'(nt_q) * P + j < int'(n_q)) row_data[j] = acc[r][j];
  end

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      c_wr_q   <= 1'b0;
      k_q      <= '0;
      m_q      <= '0;
      n_q      <= '0;
      mt_q     <= '0;
      nt_q     <= '0;
      cnt_q    <= '0;
      a_idx_q  <= '0;
      b_idx_q  <= '0;
      c_idx_q  <= '0;
      c_data_q <= '0;
`ifdef TPU_INPUT_OFFSET_EN
      off_q    <= '0;
`endif
    end else begin
      // read data returns one cycle after issue
      rd_vld_q <= (state_q == S_FEED) && (cnt_q < {1'b0, k_q});
      case (state_q)
        S_IDLE: begin
          c_wr_q <= 1'b0;
          if (busy_q) begin
            busy_q <= 1'b0;           // end of a zero-dimension command
          end else if (in_valid) begin
            k_q    <= K;
            m_q    <= M;
            n_q    <= N;
            mt_q   <= '0;
            nt_q   <= '0;
            busy_q <= 1'b1;
`ifdef TPU_INPUT_OFFSET_EN
            off_q  <= A_offset;
`endif
            if (M != '0 && N != '0) state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_q   <= '0;
          a_idx_q <= IDX_W'(int'(mt_q) * int'(k_q));
          b_idx_q <= IDX_W'(int'(nt_q) * int'(k_q));
          state_q <= (k_q == '0) ? S_DRAIN : S_FEED;
        end
        S_FEED: begin
          if (cnt_q == {1'b0, k_q}) begin
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q + 1'b1 < {1'b0, k_q}) begin
              a_idx_q <= a_idx_q + 1'b1;
              b_idx_q <= b_idx_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q == CNT_W'(2 * P - 2)) begin
            cnt_q    <= '0;
            state_q  <= S_WRITE;
            c_wr_q   <= row_ok;
            c_idx_q  <= c_base;
            c_data_q <= row_data;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (cnt_q == CNT_W'(P - 1)) begin
            c_wr_q <= 1'b0;
            cnt_q  <= '0;
            if (!last_mt) begin
              mt_q    <= mt_q + 1'b1;
              state_q <= S_LOAD;
            end else if (!last_nt) begin
              mt_q    <= '0;
              nt_q    <= nt_q + 1'b1;
              state_q <= S_LOAD;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            c_wr_q   <= row_ok;
            c_idx_q  <= c_idx_q + 1'b1;
            c_data_q <= row_data;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- input skew + PE grid ----------------
  logic clr;
  assign clr = (state_q == S_LOAD);

  logic [DATA_W-1:0] a_h [P][P+1];   // a_h[i][j]: west input of PE(i,j)
  logic [DATA_W-1:0] b_v [P+1][P];   // b_v[i][j]: north input of PE(i,j)

  for (genvar i = 0; i < P; i++) begin : g_skew
    logic [DATA_W-1:0] a_in, b_in;
    // zeros outside the valid read window keep the array clean between tiles
    assign a_in = rd_vld_q ? A_data_out[i*DATA_W +: DATA_W] : '0;
    assign b_in = rd_vld_q ? B_data_out[i*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_in;
      assign b_v[0][0] = b_in;
    end else begin : g_delay
      logic [DATA_W-1:0] a_sr_q [i];
      logic [DATA_W-1:0] b_sr_q [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < i; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
        end else begin
          a_sr_q[0] <= a_in;
          b_sr_q[0] <= b_in;
          for (int s = 1; s < i; s++) begin
            a_sr_q[s] <= a_sr_q[s-1];
            b_sr_q[s] <= b_sr_q[s-1];
          end
        end
      end
      assign a_h[i][0] = a_sr_q[i-1];
      assign b_v[0][i] = b_sr_q[i-1];
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_row
    for (genvar j = 0; j < P; j++) begin : g_col
      tpu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .a_i   (a_h[i][j]),
        .b_i   (b_v[i][j]),
`ifdef TPU_INPUT_OFFSET_EN
        .off_i (off_q),
`endif
        .a_o   (a_h[i][j+1]),
        .b_o   (b_v[i+1][j]),
        .acc_o (acc[i][j])
      );
    end
  end

  // grid edge outputs and C read-back are intentionally unconsumed
  logic unused_ok;
  always_comb begin
    unused_ok = ^C_data_out;
    for (int i = 0; i < P; i++) unused_ok = unused_ok ^ (^a_h[i][P]) ^ (^b_v[P][i]);
  end

  // ---------------- outputs ----------------
  assign busy      = busy_q;
  assign A_wr_en   = 1'b0;
  assign A_data_in = '0;
  assign A_index   = a_idx_q;
  assign B_wr_en   = 1'b0;
  assign B_data_in = '0;
  assign B_index   = b_idx_q;
  assign C_wr_en   = c_wr_q;
  assign C_index   = c_idx_q;
  assign C_data_in = c_data_q;

endmodule

// File: tb/tb_tpu_systolic_core.sv
// -----------------------------------------------------------------------------
// tb_tpu_systolic_core
//   Scoreboard bench: each command packs A/B into behavioural sync-read SRAMs,
//   pushes the golden C writes (in tile order) to a queue, and a negedge monitor
//   pops and compares every C write. Busy length and reset behaviour checked.
// -----------------------------------------------------------------------------
module tb_tpu_systolic_core;

  localparam int P = 4, DATA_W = 8, ACC_W = 32, DIM_W = 8, IDX_W = 16;
  localparam int CW = P * ACC_W;

  logic clk, rst_n, in_valid, busy;
  logic [DIM_W-1:0] K, M, N;
  logic A_wr_en, B_wr_en, C_wr_en;
  logic [IDX_W-1:0] A_index, B_index, C_index;
  logic [P*DATA_W-1:0] A_data_in, A_data_out, B_data_in, B_data_out;
  logic [P*ACC_W-1:0] C_data_in, C_data_out;
`ifdef TPU_INPUT_OFFSET_EN
  logic signed [DATA_W:0] A_offset;
`endif

  tpu_systolic_core #(.P(P), .DATA_W(DATA_W), .ACC_W(ACC_W), .DIM_W(DIM_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .K(K), .M(M), .N(N),
`ifdef TPU_INPUT_OFFSET_EN
    .A_offset(A_offset),
`endif
    .busy(busy),
    .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in), .A_data_out(A_data_out),
    .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in), .B_data_out(B_data_out),
    .C_wr_en(C_wr_en), .C_index(C_index), .C_data_in(C_data_in), .C_data_out(C_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural 1-cycle sync-read buffers
  logic [P*DATA_W-1:0] amem [1024];
  logic [P*DATA_W-1:0] bmem [1024];
  always @(posedge clk) begin
    A_data_out <= (A_index < 1024) ? amem[A_index] : '0;
    B_data_out <= (B_index < 1024) ? bmem[B_index] : '0;
  end
  assign C_data_out = '0;

  typedef struct { logic [IDX_W-1:0] idx; logic [CW-1:0] data; } c_exp_t;
  c_exp_t sb_q[$];

  int n_chk = 0, n_fail = 0;
  int a_m [8][256];
  int b_m [256][8];
  int off_v = 0;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // C write monitor
  always @(negedge clk) begin
    if (rst_n && C_wr_en) begin
      if (sb_q.size() == 0) chk("c_unexpected_wr", C_wr_en, 1'b0);
      else begin
        c_exp_t e;
        e = sb_q.pop_front();
        chk("c_index", C_index, e.idx);
        chk("c_data", C_data_in, e.data);
      end
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 256; k++) begin
        a_m[i][k] = int'($urandom_range(0, 255)) - 128;
        b_m[k][i] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  // pack buffers and push the golden write sequence
  task automatic prep(input int k, input int m, input int n);
    int mt_n, nt_n;
    mt_n = (m + P - 1) / P;
    nt_n = (n + P - 1) / P;
    for (int mt = 0; mt < mt_n; mt++)
      for (int kk = 0; kk < k; kk++)
        for (int i = 0; i < P; i++) begin
          logic [DATA_W-1:0] v;
          v = DATA_W'(a_m[mt*P+i][kk]);
          amem[mt*k+kk][i*DATA_W +: DATA_W] = v;
        end
    for (int nt = 0; nt < nt_n; nt++)
      for (int kk = 0; kk < k; kk++)
        for (int j = 0; j < P; j++) begin
          logic [DATA_W-1:0] v;
          v = DATA_W'(b_m[kk][nt*P+j]);
          bmem[nt*k+kk][j*DATA_W +: DATA_W] = v;
        end
    if (m == 0 || n == 0) return;
    for (int nt = 0; nt < nt_n; nt++)
      for (int mt = 0; mt < mt_n; mt++)
        for (int r = 0; r < P; r++) begin
          c_exp_t e;
          int row;
          row = mt*P + r;
          if (row >= m) continue;
          e.idx  = IDX_W'(nt*m + row);
          e.data = '0;
          for (int j = 0; j < P; j++) begin
            int col, acc;
            col = nt*P + j;
            acc = 0;
            if (col < n)
              for (int kk = 0; kk < k; kk++) begin
                logic signed [DATA_W:0] a9;
                a9 = (DATA_W+1)'(a_m[row][kk] + off_v);
                acc += int'(a9) * b_m[kk][col];
              end
            e.data[j*ACC_W +: ACC_W] = acc;
          end
          sb_q.push_back(e);
        end
  endtask

  function automatic int exp_busy(input int k, input int m, input int n);
    if (m == 0 || n == 0) return 1;
    return ((m+P-1)/P) * ((n+P-1)/P) * (1 + (k == 0 ? 0 : k+1) + 2*P-1 + P);
  endfunction

  // issue command, count busy cycles; optional ignored command at busy cycle 'poke'
  task automatic run_cmd(input string tag, input int k, input int m, input int n, input int poke);
    int bc;
    bit done;
    @(posedge clk); #1;
    in_valid = 1'b1; K = DIM_W'(k); M = DIM_W'(m); N = DIM_W'(n);
`ifdef TPU_INPUT_OFFSET_EN
    A_offset = (DATA_W+1)'(off_v);
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    bc = 0; done = 0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (busy) begin
        bc++;
        if (bc == poke) begin
          in_valid = 1'b1; K = 8'd1; M = 8'd4; N = 8'd4;
        end
      end else done = 1;
    end
    if (!done) chk({tag, "_timeout"}, busy, 1'b0);
    chk({tag, "_busy_len"}, bc, exp_busy(k, m, n));
    repeat (2) @(negedge clk);
    chk({tag, "_sb_empty"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; K = '0; M = '0; N = '0;
`ifdef TPU_INPUT_OFFSET_EN
    A_offset = '0;
`endif
    for (int i = 0; i < 1024; i++) begin amem[i] = '0; bmem[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_c_wr", C_wr_en, 1'b0);
    chk("rst_c_idx", C_index, '0);
    chk("rst_c_data", C_data_in, '0);
    chk("rst_a_idx", A_index, '0);
    chk("rst_ab_wr", {A_wr_en, B_wr_en}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: identity A, B = 1..16; a command poked mid-run must be ignored
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 256; k++) begin a_m[i][k] = (i == k) ? 1 : 0; b_m[k][i] = k*4 + i + 1; end
    prep(4, 4, 4);
    run_cmd("ident", 4, 4, 4, 5);

    // 2: random 8x8x8; poke on the last busy (last WRITE) cycle
    fill_rand();
    prep(8, 8, 8);
    run_cmd("rand8", 8, 8, 8, exp_busy(8, 8, 8));

    // 3: ragged edges, junk beyond M/N
    fill_rand();
    prep(3, 5, 6);
    run_cmd("ragged", 3, 5, 6, 0);

    // 4: K==0 -> zeros; M==0 -> no writes, 1-cycle busy
    fill_rand();
    prep(0, 4, 4);
    run_cmd("k0", 0, 4, 4, 0);
    prep(4, 0, 4);
    run_cmd("m0", 4, 0, 4, 0);

    // 5: extreme values, long K
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 256; k++) begin a_m[i][k] = -128; b_m[k][i] = -128; end
    prep(255, 4, 4);
    run_cmd("neg128", 255, 4, 4, 0);

    // 6: reset during FEED, then a clean command
    fill_rand();
    prep(8, 4, 4);
    @(posedge clk); #1;
    in_valid = 1'b1; K = 8'd8; M = 8'd4; N = 8'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_c_wr", C_wr_en, 1'b0);
    chk("midrst_a_idx", A_index, '0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill_rand();
    prep(5, 4, 4);
    run_cmd("post_rst", 5, 4, 4, 0);

`ifdef TPU_INPUT_OFFSET_EN
    // zero-point: A=0, offset 128, B=1, K=4 -> 512 everywhere
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 256; k++) begin a_m[i][k] = 0; b_m[k][i] = 1; end
    off_v = 128;
    prep(4, 4, 4);
    run_cmd("offset", 4, 4, 4, 0);
    off_v = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
